field_seq_ctrl: RTL and testbench
=================================

# field_seq_ctrl

Sequencer for the registered 3-bit field selector: accepts a 16-bit word over a valid/ready handshake, then steps the selector's 2-bit select through fields 0..LAST_SEL. It drives the selector's input word, captures each returned field one cycle later, and streams the fields out with backpressure. It also accumulates their sum and pulses done when the word is finished. Sits between an instruction/operand source and the field selector instance.

## Interface
- LAST_SEL, 3, index of last field scanned (legal 0..3); fields 0..LAST_SEL are emitted per word
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_word  in  16  word to decompose; bits [1:0] ignored
- i_valid  in  1  i_word valid
- o_ready  out  1  block accepts a word this cycle
- o_dp_data  out  16  to selector input: {w_reg[15:2], idx}
- i_dp_field  in  3  selector registered output (1-cycle latency)
- o_field  out  3  extracted field
- o_idx  out  2  index of o_field
- o_valid  out  1  o_field/o_idx/o_last valid
- o_last  out  1  o_field is field LAST_SEL
- i_ready  in  1  consumer accepts field
- o_sum  out  5  sum of fields emitted for current word
- o_done  out  1  one-cycle pulse, word complete
- o_busy  out  1  state != IDLE

## Operation
- Internal regs: w_reg[15:0], idx[1:0], state ∈ {IDLE, ISSUE, CAPT, OUT}.
- o_dp_data = {w_reg[15:2], idx} continuously; held stable from ISSUE through CAPT.
- IDLE: o_ready=1. On i_valid: w_reg<=i_word, idx<=0, o_sum<=0, go ISSUE.
- ISSUE: selector registers o_dp_data at end of cycle; go CAPT.
- CAPT: i_dp_field valid. At edge: o_field<=i_dp_field, o_idx<=idx, o_last<=(idx==LAST_SEL), o_sum<=o_sum+i_dp_field, o_valid<=1; go OUT.
- OUT: hold o_field/o_idx/o_last/o_valid until i_ready. On handshake: o_valid<=0; if idx==LAST_SEL → o_done<=1, go IDLE; else idx<=idx+1, go ISSUE.
- o_sum: 5-bit, max 4×7=28, no overflow. Holds final value after done until next word accepted.
- Output regs o_field/o_idx/o_last change only at CAPT edge; stable while o_valid && !i_ready.
- o_ready = (state==IDLE) && !i_rst (combinational); o_busy = (state!=IDLE).

## Timing
- Reset: state=IDLE, w_reg=0, idx=0, o_field=0, o_idx=0, o_last=0, o_valid=0, o_sum=0, o_done=0; o_dp_data=16'h0000.
- Reset mid-word: word and pending fields discarded; no o_done. Reset dominates i_valid.
- Accept edge T: ISSUE in T+1, CAPT in T+2, o_valid=1 in T+3.
- With i_ready=1: one field per 3 cycles; word of N=LAST_SEL+1 fields completes in 3N cycles after accept.
- o_done=1 in first IDLE cycle after final handshake, one cycle only. o_sum is final in that cycle.
- New word may be accepted in the o_done cycle; o_sum clears at that edge.
- i_valid while busy: ignored (o_ready=0); source must hold.
- i_ready asserted while o_valid=0: no effect.

## Test plan
- Reset, LAST_SEL=3, i_word=16'h0F54 accepted, i_ready=1 → o_field 5,2,7,1 with o_idx 0..3. o_valid first 3 cycles after accept, spaced 3 cycles. o_last only on idx 3. o_sum=15, o_done one pulse.
- i_word=16'hFFFF → fields 7,7,7,7; o_sum=28 (5'b11100); bits [1:0] of input don't alter order.
- Backpressure: 16'h0F54, i_ready low 5 cycles when o_idx=1 → o_field=2 held stable, o_valid high, no idx advance; resumes correctly.
- LAST_SEL=1, 16'h0F54 → only fields 5,2; o_last on idx 1; o_sum=7; done after 6 cycles.
- Back-to-back: second word 16'hFFFF presented during o_done cycle → accepted same cycle, o_sum clears, first field 7 after 3 cycles.
- i_rst asserted while in OUT with idx=2 → next cycle all outputs at reset values, o_done not pulsed, o_ready=1 once reset released.

Source files
------------

// File: rtl/field_seq_ctrl_if.sv
// ============================================================================
// Module      : field_seq_ctrl_if
// Description : Word/field handshake bundle between source, sequencer,
//               selector and field consumer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface field_seq_ctrl_if;
    logic [15:0] i_word;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_dp_data;
    logic [2:0]  i_dp_field;
    logic [2:0]  o_field;
    logic [1:0]  o_idx;
    logic        o_valid;
    logic        o_last;
    logic        i_ready;
    logic [4:0]  o_sum;
    logic        o_done;
    logic        o_busy;

    modport slave (
        input  i_word, i_valid, i_dp_field, i_ready,
        output o_ready, o_dp_data, o_field, o_idx, o_valid, o_last,
               o_sum, o_done, o_busy
    );

    modport master (
        output i_word, i_valid, i_dp_field, i_ready,
        input  o_ready, o_dp_data, o_field, o_idx, o_valid, o_last,
               o_sum, o_done, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/field_seq_ctrl.sv
// ============================================================================
// Module      : field_seq_ctrl
// Description : Steps an external registered field selector through fields
//               0..LAST_SEL of an accepted word and streams them out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module field_seq_ctrl #(
    parameter int LAST_SEL = 3
) (
    input  wire              i_clk,
    input  wire              i_rst,
    field_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] c_last_idx = 2'(LAST_SEL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [13:0] r_word,  w_word_nxt;
    logic [1:0]  r_idx,   w_idx_nxt;
    logic [2:0]  r_field, w_field_nxt;
    logic [1:0]  r_oidx,  w_oidx_nxt;
    logic        r_last,  w_last_nxt;
    logic        r_valid, w_valid_nxt;
    logic [4:0]  r_sum,   w_sum_nxt;
    logic        r_done,  w_done_nxt;

    // Low two bits of the word are replaced by the select index downstream.
    wire [1:0] w_unused_bits = bus.i_word[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_field <= '0;
            r_oidx  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
            r_field <= w_field_nxt;
            r_oidx  <= w_oidx_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
            r_sum   <= w_sum_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
        w_field_nxt = r_field;
        w_oidx_nxt  = r_oidx;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        w_sum_nxt   = r_sum;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid) begin
                    w_word_nxt  = bus.i_word[15:2];
                    w_idx_nxt   = 2'd0;
                    w_sum_nxt   = 5'd0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_CAPT;
            end
            S_CAPT: begin
                // Selector output now reflects the select issued last cycle.
                w_field_nxt = bus.i_dp_field;
                w_oidx_nxt  = r_idx;
                w_last_nxt  = (r_idx == c_last_idx);
                w_sum_nxt   = r_sum + {2'b00, bus.i_dp_field};
                w_valid_nxt = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.i_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_idx == c_last_idx) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_ready   = (r_state == S_IDLE) && !i_rst;
    assign bus.o_busy    = (r_state != S_IDLE);
    assign bus.o_dp_data = {r_word, r_idx};
    assign bus.o_field   = r_field;
    assign bus.o_idx     = r_oidx;
    assign bus.o_last    = r_last;
    assign bus.o_valid   = r_valid;
    assign bus.o_sum     = r_sum;
    assign bus.o_done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_field_seq_ctrl.sv
// ============================================================================
// Module      : tb_field_seq_ctrl
// Description : Randomized and directed checks of field_seq_ctrl (LAST_SEL 3
//               and 1) against a transaction-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_field_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] word_in [2];
    logic        valid_in[2];
    logic        rdy_in  [2];
    logic [30:0] obs     [2];
    bit          chk_en;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    field_seq_ctrl_if bus0();
    field_seq_ctrl_if bus1();

    field_seq_ctrl #(.LAST_SEL(3)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    field_seq_ctrl #(.LAST_SEL(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    assign bus0.i_word  = word_in[0];
    assign bus0.i_valid = valid_in[0];
    assign bus0.i_ready = rdy_in[0];
    assign bus1.i_word  = word_in[1];
    assign bus1.i_valid = valid_in[1];
    assign bus1.i_ready = rdy_in[1];

    assign obs[0] = {bus0.o_ready, bus0.o_busy, bus0.o_valid, bus0.o_last, bus0.o_done,
                     bus0.o_field, bus0.o_idx, bus0.o_sum, bus0.o_dp_data};
    assign obs[1] = {bus1.o_ready, bus1.o_busy, bus1.o_valid, bus1.o_last, bus1.o_done,
                     bus1.o_field, bus1.o_idx, bus1.o_sum, bus1.o_dp_data};

    // Environment: registered selector returns field data[1:0] of the word.
    function automatic logic [2:0] sel_field(input logic [15:0] d);
        logic [15:0] t;
        t = d >> (3 * int'(d[1:0]) + 2);
        return t[2:0];
    endfunction

    always @(posedge clk) begin
        bus0.i_dp_field <= sel_field(bus0.o_dp_data);
        bus1.i_dp_field <= sel_field(bus1.o_dp_data);
    end

    // Reference model: per word, field k is (word >> (3k+2)) & 7; each field
    // takes two quiet cycles before it is offered, then waits for i_ready.
    bit          m_busy [2];
    logic [15:0] m_word [2];
    int          m_k    [2];
    int          m_cnt  [2];
    bit          m_valid[2];
    bit          m_last [2];
    bit          m_done [2];
    int          m_field[2];
    int          m_idx  [2];
    int          m_sum  [2];
    int acc0[$], acc1[$], done0[$], done1[$], log0[$], log1[$], sum0[$], sum1[$];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int last;
            last = (d == 0) ? 3 : 1;
            if (rst) begin
                m_busy[d] = 0; m_word[d] = '0; m_k[d] = 0; m_cnt[d] = 0;
                m_valid[d] = 0; m_last[d] = 0; m_done[d] = 0;
                m_field[d] = 0; m_idx[d] = 0; m_sum[d] = 0;
            end else begin
                m_done[d] = 0;
                if (!m_busy[d]) begin
                    if (valid_in[d]) begin
                        m_busy[d] = 1; m_word[d] = word_in[d]; m_k[d] = 0;
                        m_sum[d] = 0; m_cnt[d] = 1;
                        if (d == 0) acc0.push_back(cyc); else acc1.push_back(cyc);
                    end
                end else if (m_valid[d]) begin
                    if (rdy_in[d]) begin
                        m_valid[d] = 0;
                        if (d == 0) log0.push_back(m_field[d]); else log1.push_back(m_field[d]);
                        if (m_k[d] == last) begin
                            m_busy[d] = 0; m_done[d] = 1;
                            if (d == 0) begin sum0.push_back(m_sum[d]); done0.push_back(cyc + 1); end
                            else        begin sum1.push_back(m_sum[d]); done1.push_back(cyc + 1); end
                        end else begin
                            m_k[d]++; m_cnt[d] = 1;
                        end
                    end
                end else if (m_cnt[d] > 0) begin
                    m_cnt[d]--;
                end else begin
                    m_valid[d] = 1;
                    m_field[d] = int'((m_word[d] >> (3 * m_k[d] + 2)) & 16'h7);
                    m_idx[d]   = m_k[d];
                    m_last[d]  = (m_k[d] == last);
                    m_sum[d]   = m_sum[d] + m_field[d];
                end
            end
        end
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [30:0] e;
                e = {!m_busy[d] && !rst, m_busy[d], m_valid[d], m_last[d], m_done[d],
                     3'(m_field[d]), 2'(m_idx[d]), 5'(m_sum[d]),
                     m_word[d][15:2], 2'(m_k[d])};
                check(d == 0 ? "cycle outputs dut0" : "cycle outputs dut1",
                      {1'b0, obs[d]}, {1'b0, e});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_size(input string nm, input int which, input int n, input int budget);
        int b;
        int sz;
        b = 0;
        forever begin
            case (which)
                0: sz = acc0.size();
                1: sz = done0.size();
                default: sz = done1.size();
            endcase
            if (sz >= n || b >= budget) break;
            tick();
            b++;
        end
        check(nm, {31'd0, sz >= n}, 32'd1);
    endtask

    task automatic wait_out(input string nm, input int idx);
        int b;
        b = 0;
        while (!(m_valid[0] && m_idx[0] == idx) && b < 40) begin
            tick();
            b++;
        end
        check(nm, {31'd0, m_valid[0] && m_idx[0] == idx}, 32'd1);
    endtask

    initial begin
        int exp_f0[8];
        int exp_f1[2];
        exp_f0 = '{5, 2, 7, 1, 7, 7, 7, 7};
        exp_f1 = '{5, 2};
        rst = 1'b1; chk_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            word_in[d] = '0; valid_in[d] = 1'b0; rdy_in[d] = 1'b1;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        check("reset state", {1'b0, obs[0]}, 32'h0000_0000);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", {1'b0, obs[0]}, 32'h4000_0000);
        #1;

        // Back-to-back words on LAST_SEL=3, single word on LAST_SEL=1.
        word_in[0] = 16'h0F54; valid_in[0] = 1'b1;
        word_in[1] = 16'h0F54; valid_in[1] = 1'b1;
        tick();
        word_in[0] = 16'hFFFF; valid_in[1] = 1'b0;
        wait_size("second accept", 0, 2, 40);
        valid_in[0] = 1'b0;
        wait_size("second done", 1, 2, 40);
        wait_size("dut1 done", 2, 1, 40);
        for (int i = 0; i < 8; i++) check("fields last3", log0[i], exp_f0[i]);
        check("sum 0F54", sum0[0], 15);
        check("sum FFFF", sum0[1], 28);
        check("word latency 4 fields", done0[0] - acc0[0], 13);
        check("accept in done cycle", acc0[1], done0[0]);
        for (int i = 0; i < 2; i++) check("fields last1", log1[i], exp_f1[i]);
        check("sum last1", sum1[0], 7);
        check("word latency 2 fields", done1[0] - acc1[0], 7);

        // Backpressure while field 1 is offered.
        log0.delete();
        word_in[0] = 16'h0F54; valid_in[0] = 1'b1;
        wait_size("bp accept", 0, 3, 20);
        valid_in[0] = 1'b0;
        wait_out("bp reach idx1", 1);
        rdy_in[0] = 1'b0;
        repeat (5) begin
            tick();
            check("bp held field", {29'd0, bus0.o_field}, 32'd2);
            check("bp held valid/idx", {29'd0, bus0.o_valid, bus0.o_idx}, 32'h5);
        end
        rdy_in[0] = 1'b1;
        wait_size("bp done", 1, 3, 40);
        check("bp sum", sum0[2], 15);
        check("bp field order", {log0[0], log0[1]}, {32'd5, 32'd2});

        // Reset while holding field 2.
        word_in[0] = 16'h0F54; valid_in[0] = 1'b1;
        wait_size("rst accept", 0, 4, 20);
        valid_in[0] = 1'b0;
        wait_out("rst reach idx2", 2);
        rdy_in[0] = 1'b0;
        rst = 1'b1;
        tick();
        check("mid-word reset", {1'b0, obs[0]}, 32'h0000_0000);
        rst = 1'b0; rdy_in[0] = 1'b1;
        @(negedge clk);
        check("ready after mid reset", {1'b0, obs[0]}, 32'h4000_0000);
        #1;
        repeat (15) tick();
        check("no done after reset", done0.size(), 3);

        // Randomized traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                valid_in[d] = ($urandom % 3) != 0;
                word_in[d]  = 16'($urandom);
                rdy_in[d]   = ($urandom % 4) != 0;
            end
            rst = ($urandom % 250) == 0;
            tick();
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid_in[d] = 1'b0; rdy_in[d] = 1'b1;
        end
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
